// File: rtl/sync_cmd_arbiter_if.sv
// Command port bundle between the HOST/AUX requesters and the sync-unit configuration arbiter.
// The requester side drives valid/op/data plus the sync-unit status; the arbiter returns handshakes and strobes.
interface sync_cmd_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic                  host_valid;
  logic [1:0]            host_op;
  logic [DATA_WIDTH-1:0] host_data;
  logic                  host_ready;
  logic                  aux_valid;
  logic [1:0]            aux_op;
  logic [DATA_WIDTH-1:0] aux_data;
  logic                  aux_ready;
  logic                  sync_in;
  logic                  running;
  logic                  state_change;
  logic                  interval_change;
  logic                  sa_reload_change;
  logic [DATA_WIDTH-1:0] data;
  logic                  busy;
  logic                  err;

  modport master (
    output en, host_valid, host_op, host_data, aux_valid, aux_op, aux_data, sync_in, running,
    input  host_ready, aux_ready, state_change, interval_change, sa_reload_change, data, busy, err
  );

  modport slave (
    input  en, host_valid, host_op, host_data, aux_valid, aux_op, aux_data, sync_in, running,
    output host_ready, aux_ready, state_change, interval_change, sa_reload_change, data, busy, err
  );
endinterface

// File: rtl/sync_cmd_arbiter.sv
// Round-robin arbiter sharing the sync unit's configuration port between HOST and AUX requesters.
// Interval/SA-reload writes issued while running wait for the next cycle boundary; a guard gap follows each issue.
module sync_cmd_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input logic               CGRA_CLK_I,
  input logic               RST_I,
  sync_cmd_arbiter_if.slave cmd
);

  localparam int unsigned WW = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam int unsigned GW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);

  localparam logic [1:0]    OP_STATE    = 2'd0;
  localparam logic [1:0]    OP_INTERVAL = 2'd1;
  localparam logic [1:0]    OP_SA_RELOAD = 2'd2;
  localparam logic [1:0]    OP_ILLEGAL  = 2'd3;
  localparam logic [WW:0]   WAIT_LIMIT  = (WW + 1)'(WAIT_TIMEOUT);
  localparam logic [WW:0]   WAIT_ONE    = (WW + 1)'(1);
  localparam logic [GW-1:0] GUARD_LOAD  = GW'(GUARD_CYCLES);
  localparam logic [GW-1:0] GUARD_ONE   = GW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic [1:0]            op_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  last_aux_r;
  logic [WW-1:0]         wait_cnt_r;
  logic [WW:0]           wait_inc_s;
  logic [GW-1:0]         guard_cnt_r;
  logic                  err_r;
  logic                  err_set_s;
  logic                  grant_host_s;
  logic                  grant_aux_s;
  logic                  accept_s;
  logic [1:0]            acc_op_s;
  logic [DATA_WIDTH-1:0] acc_data_s;
  logic                  issue_s;

  assign wait_inc_s = {1'b0, wait_cnt_r} + WAIT_ONE;

  // Grant selection: only in IDLE while enabled; on contention the requester not granted last wins.
  always_comb begin
    grant_host_s = 1'b0;
    grant_aux_s  = 1'b0;
    if ((state_r == ST_IDLE) && cmd.en && !RST_I) begin
      if (cmd.host_valid && cmd.aux_valid) begin
        grant_host_s = last_aux_r;
        grant_aux_s  = ~last_aux_r;
      end else begin
        grant_host_s = cmd.host_valid;
        grant_aux_s  = cmd.aux_valid;
      end
    end else begin
      grant_host_s = 1'b0;
      grant_aux_s  = 1'b0;
    end
    accept_s   = grant_host_s | grant_aux_s;
    acc_op_s   = grant_aux_s ? cmd.aux_op : cmd.host_op;
    acc_data_s = grant_aux_s ? cmd.aux_data : cmd.host_data;
  end

  // Next-state and error-pulse decode; a disabled cycle holds everything.
  always_comb begin
    next_state_s = state_r;
    err_set_s    = 1'b0;
    if (cmd.en) begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (acc_op_s == OP_ILLEGAL) begin
              err_set_s    = 1'b1;
              next_state_s = ST_IDLE;
            end else if ((acc_op_s == OP_STATE) || !cmd.running) begin
              next_state_s = ST_ISSUE;
            end else begin
              next_state_s = ST_WAIT;
            end
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          // A boundary or a stopped sync unit releases the command; otherwise the timeout forces it out.
          if (cmd.sync_in || !cmd.running) begin
            next_state_s = ST_ISSUE;
          end else if (wait_inc_s >= WAIT_LIMIT) begin
            err_set_s    = 1'b1;
            next_state_s = ST_ISSUE;
          end else begin
            next_state_s = ST_WAIT;
          end
        end
        ST_ISSUE: begin
          if (GUARD_CYCLES == 0) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (guard_cnt_r <= GUARD_ONE) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_GUARD;
          end
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end else begin
      next_state_s = state_r;
      err_set_s    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CGRA_CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Hold registers, round-robin pointer and the wait/guard counters.
  always_ff @(posedge CGRA_CLK_I or posedge RST_I) begin
    if (RST_I) begin
      op_r        <= OP_STATE;
      data_r      <= '0;
      last_aux_r  <= 1'b1;
      wait_cnt_r  <= '0;
      guard_cnt_r <= '0;
    end else if (cmd.en) begin
      if (accept_s) begin
        op_r       <= acc_op_s;
        data_r     <= acc_data_s;
        last_aux_r <= grant_aux_s;
        wait_cnt_r <= '0;
      end
      if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_inc_s[WW-1:0];
      end
      if (state_r == ST_ISSUE) begin
        guard_cnt_r <= GUARD_LOAD;
      end else if ((state_r == ST_GUARD) && (guard_cnt_r != '0)) begin
        guard_cnt_r <= guard_cnt_r - GUARD_ONE;
      end
    end
  end

  // Error pulse register: high for exactly the cycle after the event.
  always_ff @(posedge CGRA_CLK_I or posedge RST_I) begin
    if (RST_I) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_set_s;
    end
  end

  assign issue_s              = (state_r == ST_ISSUE) && cmd.en;
  assign cmd.state_change     = issue_s && (op_r == OP_STATE);
  assign cmd.interval_change  = issue_s && (op_r == OP_INTERVAL);
  assign cmd.sa_reload_change = issue_s && (op_r == OP_SA_RELOAD);
  assign cmd.host_ready       = grant_host_s;
  assign cmd.aux_ready        = grant_aux_s;
  assign cmd.data             = data_r;
  assign cmd.busy             = (state_r != ST_IDLE);
  assign cmd.err              = err_r;

endmodule

// File: tb/tb_sync_cmd_arbiter.sv
// Bench for sync_cmd_arbiter: two instances (default timeout and a short timeout of 4) share one stimulus,
// a command-level model predicts every output each cycle, and directed checks pin the model with literals.
module tb_sync_cmd_arbiter;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        hv = 1'b0;
  logic [1:0]  hop = 2'd0;
  logic [31:0] hd = 32'd0;
  logic        av = 1'b0;
  logic [1:0]  aop = 2'd0;
  logic [31:0] ad = 32'd0;
  logic        sync_in = 1'b0;
  logic        running = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sync_cmd_arbiter_if #(.DATA_WIDTH(32)) if0 ();
  sync_cmd_arbiter_if #(.DATA_WIDTH(32)) if1 ();

  assign if0.en = en;          assign if1.en = en;
  assign if0.host_valid = hv;  assign if1.host_valid = hv;
  assign if0.host_op = hop;    assign if1.host_op = hop;
  assign if0.host_data = hd;   assign if1.host_data = hd;
  assign if0.aux_valid = av;   assign if1.aux_valid = av;
  assign if0.aux_op = aop;     assign if1.aux_op = aop;
  assign if0.aux_data = ad;    assign if1.aux_data = ad;
  assign if0.sync_in = sync_in; assign if1.sync_in = sync_in;
  assign if0.running = running; assign if1.running = running;

  sync_cmd_arbiter #(.DATA_WIDTH(32), .GUARD_CYCLES(G), .WAIT_TIMEOUT(255)) u_dut (
    .CGRA_CLK_I(clk), .RST_I(rst), .cmd(if0.slave));
  sync_cmd_arbiter #(.DATA_WIDTH(32), .GUARD_CYCLES(G), .WAIT_TIMEOUT(4)) u_dut_to (
    .CGRA_CLK_I(clk), .RST_I(rst), .cmd(if1.slave));

  // Command-level model: one held command, whether it is still deferred, and guard cycles remaining.
  logic        m_has[2];
  logic        m_defer[2];
  logic [1:0]  m_op[2];
  logic [31:0] m_data[2];
  int          m_wait[2];
  int          m_guard[2];
  logic        m_last_aux[2];
  logic        m_err[2];

  function automatic int timeout_of(input int k);
    return (k == 0) ? 255 : 4;
  endfunction

  function automatic logic m_busy(input int k);
    return m_has[k] || (m_guard[k] > 0);
  endfunction

  // {host grant, aux grant} the model allows this cycle.
  function automatic logic [1:0] m_grant(input int k);
    if (rst || !en || m_busy(k)) return 2'b00;
    if (hv && av) return m_last_aux[k] ? 2'b10 : 2'b01;
    return {hv, av};
  endfunction

  function automatic logic [38:0] m_expect(input int k);
    logic due;
    logic [1:0] g;
    if (rst) return 39'd0;
    due = m_has[k] && !m_defer[k] && en;
    g = m_grant(k);
    return {g[1], g[0], due && (m_op[k] == 2'd0), due && (m_op[k] == 2'd1),
            due && (m_op[k] == 2'd2), m_busy(k), m_err[k], m_data[k]};
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_has[k] <= 1'b0; m_defer[k] <= 1'b0; m_op[k] <= 2'd0; m_data[k] <= 32'd0;
        m_wait[k] <= 0; m_guard[k] <= 0; m_last_aux[k] <= 1'b1; m_err[k] <= 1'b0;
      end else begin
        m_err[k] <= 1'b0;
        if (en) begin
          if (m_has[k] && !m_defer[k]) begin
            m_has[k] <= 1'b0;
            m_guard[k] <= G;
          end else if (m_guard[k] > 0) begin
            m_guard[k] <= m_guard[k] - 1;
          end else if (m_has[k]) begin
            m_wait[k] <= m_wait[k] + 1;
            if (sync_in || !running) begin
              m_defer[k] <= 1'b0;
            end else if (m_wait[k] + 1 >= timeout_of(k)) begin
              m_defer[k] <= 1'b0;
              m_err[k] <= 1'b1;
            end
          end else if (m_grant(k) != 2'b00) begin
            m_last_aux[k] <= m_grant(k)[0];
            m_data[k] <= m_grant(k)[0] ? ad : hd;
            if ((m_grant(k)[0] ? aop : hop) == 2'd3) begin
              m_err[k] <= 1'b1;
            end else begin
              m_has[k] <= 1'b1;
              m_op[k] <= m_grant(k)[0] ? aop : hop;
              m_defer[k] <= ((m_grant(k)[0] ? aop : hop) != 2'd0) && running;
              m_wait[k] <= 0;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model, away from the active edge.
  always @(negedge clk) begin
    logic [38:0] act0;
    logic [38:0] act1;
    act0 = {if0.host_ready, if0.aux_ready, if0.state_change, if0.interval_change,
            if0.sa_reload_change, if0.busy, if0.err, if0.data};
    act1 = {if1.host_ready, if1.aux_ready, if1.state_change, if1.interval_change,
            if1.sa_reload_change, if1.busy, if1.err, if1.data};
    total = total + 1;
    if (act0 !== m_expect(0)) begin
      bad = bad + 1;
      $display("FAIL model_dut0 t=%0t actual=%h required=%h", $time, act0, m_expect(0));
    end
    total = total + 1;
    if (act1 !== m_expect(1)) begin
      bad = bad + 1;
      $display("FAIL model_dut1 t=%0t actual=%h required=%h", $time, act1, m_expect(1));
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hcnt;
    int acnt;
    int gn;
    int nstrb;
    int s0;
    int s1;
    int e1;
    logic [7:0] gseq;

    // Reset state: READY stays low even with a valid request present.
    hv = 1'b1;
    #3;
    chk("reset_ready", {63'd0, if0.host_ready}, 64'd0);
    chk("reset_busy", {63'd0, if0.busy}, 64'd0);
    chk("reset_data", {32'd0, if0.data}, 64'd0);
    @(posedge clk);
    cyc();
    rst = 1'b0;
    hv = 1'b0;

    // Test 1: HOST STATE command, undeferred.
    hv = 1'b1; hop = 2'd0; hd = 32'h0001_0004; running = 1'b0;
    #3 chk("t1_ready_t0", {63'd0, if0.host_ready}, 64'd1);
    cyc(); hv = 1'b0;
    #3 chk("t1_strobe_t1", {63'd0, if0.state_change}, 64'd1);
    chk("t1_data_t1", {32'd0, if0.data}, 64'h0001_0004);
    chk("t1_busy_t1", {63'd0, if0.busy}, 64'd1);
    cyc();
    #3 chk("t1_busy_t2", {62'd0, if0.busy, if0.state_change}, 64'd2);
    cyc();
    #3 chk("t1_busy_t3", {63'd0, if0.busy}, 64'd1);
    cyc();
    #3 chk("t1_idle_t4", {63'd0, if0.busy}, 64'd0);
    cyc();

    // Test 2: both requesters contending, four commands each.
    hcnt = 0; acnt = 0; gn = 0; nstrb = 0; gseq = 8'd0;
    hop = 2'd0; aop = 2'd0;
    for (int c = 0; c < 60 && gn < 8; c++) begin
      hd = 32'h100 + 32'(hcnt); ad = 32'h200 + 32'(acnt);
      hv = (hcnt < 4); av = (acnt < 4);
      #3;
      if (if0.state_change) nstrb = nstrb + 1;
      if (if0.host_ready) begin
        gseq[gn] = 1'b0; gn = gn + 1; hcnt = hcnt + 1;
      end else if (if0.aux_ready) begin
        gseq[gn] = 1'b1; gn = gn + 1; acnt = acnt + 1;
      end
      cyc();
    end
    hv = 1'b0; av = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #3;
      if (if0.state_change) nstrb = nstrb + 1;
      cyc();
    end
    chk("t2_grant_count", 64'(gn), 64'd8);
    chk("t2_grant_order", {56'd0, gseq}, 64'h55);
    chk("t2_strobe_count", 64'(nstrb), 64'd8);

    // Test 3: AUX INTERVAL while running, boundary at t+7; the short-timeout instance times out first.
    av = 1'b1; aop = 2'd1; ad = 32'd100; running = 1'b1;
    #3 chk("t3_aux_ready", {63'd0, if0.aux_ready}, 64'd1);
    cyc(); av = 1'b0;
    s0 = 0; s1 = 0; e1 = 0; nstrb = 0;
    for (int i = 1; i <= 10; i++) begin
      sync_in = (i == 7);
      #3;
      if (if0.interval_change) begin nstrb = nstrb + 1; s0 = i; end
      if (if1.interval_change) s1 = i;
      if (if1.err) e1 = i;
      cyc();
    end
    sync_in = 1'b0;
    chk("t3_strobe_cycle", 64'(s0), 64'd8);
    chk("t3_strobe_count", 64'(nstrb), 64'd1);
    chk("t3_to_strobe_cycle", 64'(s1), 64'd5);
    chk("t3_to_err_cycle", 64'(e1), 64'd5);

    // Test 4: SA_RELOAD while running, no boundary; timeout of 4 forces the issue.
    hv = 1'b1; hop = 2'd2; hd = 32'h0000_0ABC;
    #3 chk("t4_host_ready", {63'd0, if1.host_ready}, 64'd1);
    cyc(); hv = 1'b0;
    s1 = 0; e1 = 0;
    for (int i = 1; i <= 6; i++) begin
      #3;
      if (if1.sa_reload_change && s1 == 0) s1 = i;
      if (if1.err && e1 == 0) e1 = i;
      cyc();
    end
    chk("t4_strobe_cycle", 64'(s1), 64'd5);
    chk("t4_err_cycle", 64'(e1), 64'd5);
    running = 1'b0;
    repeat (6) cyc();

    // Test 5: illegal op raises ERR only and still advances the pointer.
    hv = 1'b1; hop = 2'd3; hd = 32'h0000_DEAD;
    #3 chk("t5_host_ready", {63'd0, if0.host_ready}, 64'd1);
    cyc();
    hv = 1'b1; av = 1'b1; hop = 2'd0; aop = 2'd0; hd = 32'h55; ad = 32'h66;
    #3 chk("t5_err_busy", {62'd0, if0.err, if0.busy}, 64'd2);
    chk("t5_grants", {62'd0, if0.host_ready, if0.aux_ready}, 64'd1);
    cyc(); hv = 1'b0; av = 1'b0;
    #3 chk("t5_strobe_data", {31'd0, if0.state_change, if0.data}, 64'h1_0000_0066);
    repeat (4) cyc();

    // Enable gating: no READY while disabled, strobe held until enable returns.
    en = 1'b0; hv = 1'b1; hop = 2'd0; hd = 32'h77;
    #3 chk("en_idle_ready", {63'd0, if0.host_ready}, 64'd0);
    cyc(); en = 1'b1;
    #3 chk("en_ready", {63'd0, if0.host_ready}, 64'd1);
    cyc(); hv = 1'b0; en = 1'b0;
    #3 chk("en_issue_held", {62'd0, if0.state_change, if0.busy}, 64'd1);
    cyc();
    #3 chk("en_issue_held2", {63'd0, if0.state_change}, 64'd0);
    cyc(); en = 1'b1;
    #3 chk("en_issue_fire", {31'd0, if0.state_change, if0.data}, 64'h1_0000_0077);
    repeat (4) cyc();

    // Test 6: reset while waiting for a boundary discards the command; pointer back to HOST.
    av = 1'b1; aop = 2'd1; ad = 32'h99; running = 1'b1;
    #3 chk("t6_aux_ready", {63'd0, if0.aux_ready}, 64'd1);
    cyc(); av = 1'b0;
    cyc();
    rst = 1'b1;
    #1 chk("t6_rst_outputs", {57'd0, if0.busy, if0.err, if0.interval_change, if1.busy,
                               if1.interval_change, (if0.data != 32'd0), (if1.data != 32'd0)}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    hv = 1'b1; av = 1'b1; hop = 2'd0; aop = 2'd0; hd = 32'h11; ad = 32'h22; running = 1'b0;
    #3 chk("t6_grant_host", {62'd0, if0.host_ready, if0.aux_ready}, 64'd2);
    cyc(); hv = 1'b0; av = 1'b0;
    #3 chk("t6_strobe", {30'd0, if0.interval_change, if0.state_change, if0.data}, 64'h1_0000_0011);
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
